// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int unsigned MAX_DATA_RUN_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus: req/gnt request phase, rvalid response phase.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between fetch and M1 data accesses,
// one transaction outstanding, data priority with bounded fetch starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DATA_RUN = MAX_DATA_RUN_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_f,
  input  logic [ADDR_W-1:0]   if_addr_f,
  input  logic                flush_f,
  output logic [DATA_W-1:0]   if_rdata_f,
  output logic                if_valid_f,
  output logic                stall_f,

  input  logic                dm_req_m1,
  input  logic                dm_we_m1,
  input  logic [ADDR_W-1:0]   dm_addr_m1,
  input  logic [DATA_W-1:0]   dm_wdata_m1,
  input  logic [DATA_W/8-1:0] dm_be_m1,
  output logic [DATA_W-1:0]   dm_rdata_m1,
  output logic                dm_valid_m1,
  output logic                stall_m1,

  mem_port_arbiter_if.master  mem
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(MAX_DATA_RUN + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;

  logic fetch_elig;
  logic run_at_max;
  logic done;

  assign fetch_elig = if_req_f & ~flush_f;
  assign run_at_max = (run_cnt_q == CNT_W'(MAX_DATA_RUN));
  assign done       = (state_q == RESP) & mem.mem_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      drop_q    <= 1'b0;
      run_cnt_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      drop_q    <= drop_d;
      run_cnt_q <= run_cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    drop_d    = drop_q;
    run_cnt_d = run_cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        // Data wins unless fetch has waited out a full run of contended grants.
        if (dm_req_m1 && !(fetch_elig && run_at_max)) begin
          state_d   = REQ;
          owner_d   = OWN_DM;
          we_d      = dm_we_m1;
          addr_d    = dm_addr_m1;
          wdata_d   = dm_wdata_m1;
          be_d      = dm_be_m1;
          run_cnt_d = fetch_elig ? run_cnt_q + CNT_W'(1) : '0;
        end else if (fetch_elig) begin
          state_d   = REQ;
          owner_d   = OWN_IF;
          we_d      = 1'b0;
          addr_d    = if_addr_f;
          wdata_d   = '0;
          be_d      = '1;
          run_cnt_d = '0;
        end
      end
      REQ: begin
        if (owner_q == OWN_IF && flush_f) drop_d = 1'b1;
        if (mem.mem_gnt) state_d = RESP;
      end
      RESP: begin
        if (owner_q == OWN_IF && flush_f) drop_d = 1'b1;
        if (mem.mem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

  assign dm_valid_m1 = done & (owner_q == OWN_DM);
  assign if_valid_f  = done & (owner_q == OWN_IF) & ~drop_q;
  assign dm_rdata_m1 = mem.mem_rdata;
  assign if_rdata_f  = mem.mem_rdata;

  assign stall_m1 = dm_req_m1 & ~dm_valid_m1;
  assign stall_f  = if_req_f & ~if_valid_f;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: handshake timing, priority/fairness,
// flush suppression and mid-transaction reset.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              if_req_f;
  logic [ADDR_W-1:0] if_addr_f;
  logic              flush_f;
  logic [DATA_W-1:0] if_rdata_f;
  logic              if_valid_f;
  logic              stall_f;
  logic              dm_req_m1;
  logic              dm_we_m1;
  logic [ADDR_W-1:0] dm_addr_m1;
  logic [DATA_W-1:0] dm_wdata_m1;
  logic [3:0]        dm_be_m1;
  logic [DATA_W-1:0] dm_rdata_m1;
  logic              dm_valid_m1;
  logic              stall_m1;

  int vectors;
  int miscompares;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_RUN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_f    (if_req_f),
    .if_addr_f   (if_addr_f),
    .flush_f     (flush_f),
    .if_rdata_f  (if_rdata_f),
    .if_valid_f  (if_valid_f),
    .stall_f     (stall_f),
    .dm_req_m1   (dm_req_m1),
    .dm_we_m1    (dm_we_m1),
    .dm_addr_m1  (dm_addr_m1),
    .dm_wdata_m1 (dm_wdata_m1),
    .dm_be_m1    (dm_be_m1),
    .dm_rdata_m1 (dm_rdata_m1),
    .dm_valid_m1 (dm_valid_m1),
    .stall_m1    (stall_m1),
    .mem         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic       pend;
  int         grants;
  logic [9:0] got_dm;
  logic [9:0] exp_dm;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1;
    if_req_f = 1'b0; if_addr_f = '0; flush_f = 1'b0;
    dm_req_m1 = 1'b0; dm_we_m1 = 1'b0; dm_addr_m1 = '0; dm_wdata_m1 = '0; dm_be_m1 = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    go(); go();
    rst = 1'b0; #2;
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_if_valid", 32'(if_valid_f), 32'd0);
    chk("rst_dm_valid", 32'(dm_valid_m1), 32'd0);

    // 1: fetch-only read
    go(); if_req_f = 1'b1; if_addr_f = 32'h100; #2;
    chk("t1_c0_stall_f", 32'(stall_f), 32'd1);
    chk("t1_c0_mem_req", 32'(bus.mem_req), 32'd0);
    go(); bus.mem_gnt = 1'b1; #2;
    chk("t1_c1_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t1_c1_mem_addr", bus.mem_addr, 32'h100);
    chk("t1_c1_mem_we", 32'(bus.mem_we), 32'd0);
    chk("t1_c1_stall_f", 32'(stall_f), 32'd1);
    go(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00500093; #2;
    chk("t1_c2_if_valid", 32'(if_valid_f), 32'd1);
    chk("t1_c2_if_rdata", if_rdata_f, 32'h00500093);
    chk("t1_c2_stall_f", 32'(stall_f), 32'd0);
    go(); if_req_f = 1'b0; bus.mem_rvalid = 1'b0; #2;
    chk("t1_c3_if_valid", 32'(if_valid_f), 32'd0);
    chk("t1_c3_mem_req", 32'(bus.mem_req), 32'd0);

    // 2: store with grant delayed three cycles
    go(); dm_req_m1 = 1'b1; dm_we_m1 = 1'b1; dm_addr_m1 = 32'h2000;
    dm_wdata_m1 = 32'hDEADBEEF; dm_be_m1 = 4'b1111; #2;
    chk("t2_c0_stall_m1", 32'(stall_m1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      go(); bus.mem_gnt = (i == 2); if (i == 1) dm_addr_m1 = 32'hBAD0; #2;
      chk("t2_req", 32'(bus.mem_req), 32'd1);
      chk("t2_addr", bus.mem_addr, 32'h2000);
      chk("t2_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("t2_we", 32'(bus.mem_we), 32'd1);
      chk("t2_be", 32'(bus.mem_be), 32'hF);
      chk("t2_dm_valid", 32'(dm_valid_m1), 32'd0);
      chk("t2_stall_m1", 32'(stall_m1), 32'd1);
    end
    go(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; #2;
    chk("t2_done_dm_valid", 32'(dm_valid_m1), 32'd1);
    chk("t2_done_stall_m1", 32'(stall_m1), 32'd0);
    chk("t2_done_mem_req", 32'(bus.mem_req), 32'd0);
    go(); dm_req_m1 = 1'b0; dm_we_m1 = 1'b0; bus.mem_rvalid = 1'b0; #2;
    chk("t2_after_dm_valid", 32'(dm_valid_m1), 32'd0);

    // 3: continuous contention, fairness run of four
    exp_dm = 10'b0111101111;
    got_dm = '0; grants = 0; pend = 1'b0;
    for (int c = 0; c < 80 && grants < 10; c++) begin
      go();
      if (c == 0) begin
        if_req_f = 1'b1; if_addr_f = 32'h100;
        dm_req_m1 = 1'b1; dm_we_m1 = 1'b0; dm_addr_m1 = 32'h2000;
      end
      bus.mem_rvalid = pend;
      bus.mem_rdata  = 32'h0;
      bus.mem_gnt    = bus.mem_req;
      pend           = bus.mem_req;
      if (bus.mem_req) begin
        got_dm[grants] = (bus.mem_addr != 32'h100);
        grants++;
      end
      #2;
    end
    go(); if_req_f = 1'b0; dm_req_m1 = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = pend; #2;
    go(); bus.mem_rvalid = 1'b0; #2;
    chk("t3_grant_count", 32'(grants), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_grant%0d_is_dm", i), 32'(got_dm[i]), 32'(exp_dm[i]));
    end

    // 4: flush while fetch is in RESP
    go(); if_req_f = 1'b1; if_addr_f = 32'h180; #2;
    go(); bus.mem_gnt = 1'b1; #2;
    chk("t4_old_addr", bus.mem_addr, 32'h180);
    go(); bus.mem_gnt = 1'b0; flush_f = 1'b1; if_addr_f = 32'h200; #2;
    chk("t4_resp_mem_req", 32'(bus.mem_req), 32'd0);
    go(); flush_f = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0BAD; #2;
    chk("t4_dropped_if_valid", 32'(if_valid_f), 32'd0);
    chk("t4_dropped_stall_f", 32'(stall_f), 32'd1);
    go(); bus.mem_rvalid = 1'b0; #2;
    chk("t4_idle_mem_req", 32'(bus.mem_req), 32'd0);
    go(); bus.mem_gnt = 1'b1; #2;
    chk("t4_new_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t4_new_addr", bus.mem_addr, 32'h200);
    go(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h13; #2;
    chk("t4_new_if_valid", 32'(if_valid_f), 32'd1);
    chk("t4_new_if_rdata", if_rdata_f, 32'h13);
    go(); bus.mem_rvalid = 1'b0; if_req_f = 1'b0; #2;

    // 5: both request with flush active
    go(); if_req_f = 1'b1; if_addr_f = 32'h100; flush_f = 1'b1;
    dm_req_m1 = 1'b1; dm_we_m1 = 1'b0; dm_addr_m1 = 32'h2004; #2;
    go(); flush_f = 1'b0; bus.mem_gnt = 1'b1; #2;
    chk("t5_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t5_dm_granted", bus.mem_addr, 32'h2004);
    chk("t5_run_cnt", 32'(dut.run_cnt_q), 32'd0);
    go(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55; #2;
    chk("t5_dm_valid", 32'(dm_valid_m1), 32'd1);
    chk("t5_dm_rdata", dm_rdata_m1, 32'h55);
    go(); bus.mem_rvalid = 1'b0; if_req_f = 1'b0; dm_req_m1 = 1'b0; #2;

    // 6: reset in RESP followed by stray rvalid
    go(); if_req_f = 1'b1; if_addr_f = 32'h300; #2;
    go(); bus.mem_gnt = 1'b1; #2;
    chk("t6_req_addr", bus.mem_addr, 32'h300);
    go(); bus.mem_gnt = 1'b0; rst = 1'b1; #2;
    go(); rst = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD; if_addr_f = 32'h400; #2;
    chk("t6_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t6_rst_mem_addr", bus.mem_addr, 32'd0);
    chk("t6_rst_if_valid", 32'(if_valid_f), 32'd0);
    chk("t6_rst_dm_valid", 32'(dm_valid_m1), 32'd0);
    chk("t6_rst_stall_f", 32'(stall_f), 32'd1);
    chk("t6_rst_run_cnt", 32'(dut.run_cnt_q), 32'd0);
    go(); bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b1; #2;
    chk("t6_restart_req", 32'(bus.mem_req), 32'd1);
    chk("t6_restart_addr", bus.mem_addr, 32'h400);
    go(); bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77; #2;
    chk("t6_restart_if_valid", 32'(if_valid_f), 32'd1);
    chk("t6_restart_if_rdata", if_rdata_f, 32'h77);
    go(); bus.mem_rvalid = 1'b0; if_req_f = 1'b0; #2;
    chk("t6_end_stall_f", 32'(stall_f), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
